// File: rtl/reg_reader_pkg.sv
// Shared definitions for the register read-back streamer: FSM encoding and
// word/byte sizing constants.
package reg_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // At least one index bit, even for a single-byte word.
  function automatic int index_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int BYTES_PER_WORD = DEFAULT_WIDTH / 8;
  localparam int INDEX_WIDTH    = index_width(BYTES_PER_WORD);

endpackage

// File: rtl/reg_reader_register.sv
// Generic enable register used to hold the captured snapshot word.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (write_enable)
      q <= d;
  end

endmodule

// File: rtl/reg_reader.sv
// Snapshots a register word on request and streams it out byte by byte over a
// valid/ready interface, ending each word with a one-cycle done pulse.
module reg_reader
  import reg_reader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] reg_data,
  input  logic             read_req,
  output logic             busy,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             last,
  output logic             done
);

  localparam int BPW = WIDTH / 8;
  localparam int IW  = index_width(BPW);

  state_t           state;
  logic [IW-1:0]    index;
  logic [IW-1:0]    next_index;
  logic [WIDTH-1:0] snapshot;
  logic             capture;

  assign capture    = (state == IDLE) && read_req;
  assign next_index = index + IW'(1);

  register #(
    .WIDTH(WIDTH)
  ) u_snapshot (
    .clk         (clk),
    .reset       (reset),
    .write_enable(capture),
    .d           (reg_data),
    .q           (snapshot)
  );

  // Byte position counts from the end that leaves first.
  function automatic logic [7:0] select_byte(input logic [WIDTH-1:0] word,
                                             input logic [IW-1:0]    idx);
    int pos;
    pos = MSB_FIRST ? (BPW - 1 - int'(idx)) : int'(idx);
    return word[pos*8 +: 8];
  endfunction

  // byte_out is loaded from reg_data at capture because the snapshot register
  // only shows the new word after the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      busy       <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req) begin
            state      <= SEND;
            index      <= '0;
            busy       <= 1'b1;
            byte_valid <= 1'b1;
            byte_out   <= select_byte(reg_data, '0);
            last       <= (BPW == 1);
          end
        end
        SEND: begin
          if (byte_ready) begin
            if (last) begin
              state      <= DONE;
              byte_valid <= 1'b0;
              byte_out   <= 8'h00;
              last       <= 1'b0;
              done       <= 1'b1;
            end else begin
              index    <= next_index;
              byte_out <= select_byte(snapshot, next_index);
              last     <= (next_index == IW'(BPW - 1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
          index <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          index      <= '0;
          busy       <= 1'b0;
          byte_out   <= 8'h00;
          byte_valid <= 1'b0;
          last       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_reader.sv
// Scoreboard bench for reg_reader: an MSB-first and an LSB-first instance share
// the same stimulus, each with its own queue of expected bytes and done pulses.
module tb_reg_reader;

  typedef struct packed {
    logic       is_done;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_data;
  logic        read_req;
  logic        byte_ready;

  logic        busy[2];
  logic [7:0]  byte_out[2];
  logic        byte_valid[2];
  logic        last[2];
  logic        done[2];

  exp_t        exp_q[2][$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  reg_reader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .reg_data(reg_data), .read_req(read_req),
    .busy(busy[0]), .byte_out(byte_out[0]), .byte_valid(byte_valid[0]),
    .byte_ready(byte_ready), .last(last[0]), .done(done[0])
  );

  reg_reader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .reg_data(reg_data), .read_req(read_req),
    .busy(busy[1]), .byte_out(byte_out[1]), .byte_valid(byte_valid[1]),
    .byte_ready(byte_ready), .last(last[1]), .done(done[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Expected stream for one word: bytes in each instance's order, then done.
  task automatic pushWord(input logic [31:0] word, input int nbytes,
                          input bit with_done);
    for (int i = 0; i < nbytes; i++) begin
      exp_q[0].push_back('{1'b0, word[31-8*i -: 8], (i == 3)});
      exp_q[1].push_back('{1'b0, word[8*i +: 8], (i == 3)});
    end
    if (with_done) begin
      exp_q[0].push_back('{1'b1, 8'h00, 1'b0});
      exp_q[1].push_back('{1'b1, 8'h00, 1'b0});
    end
  endtask

  // Called just after a rising edge with both instances idle.
  task automatic applyStimulus(input logic [31:0] word);
    reg_data = word;
    read_req = 1'b1;
    @(posedge clk);
    #1 read_req = 1'b0;
  endtask

  task automatic checkIdle(input string name);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s.busy%0d", name, d), busy[d], 0);
      checkOutput($sformatf("%s.valid%0d", name, d), byte_valid[d], 0);
      checkOutput($sformatf("%s.done%0d", name, d), done[d], 0);
      checkOutput($sformatf("%s.last%0d", name, d), last[d], 0);
      checkOutput($sformatf("%s.byte%0d", name, d), byte_out[d], 0);
    end
  endtask

  // Count cycles until both instances are idle with nothing left to expect.
  task automatic waitDrain(input string name, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      cycles++;
      @(negedge clk);
      #1;
      if (!busy[0] && !busy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0)
        break;
    end
    checkOutput($sformatf("%s.drained", name),
                exp_q[0].size() + exp_q[1].size() + int'(busy[0]) + int'(busy[1]), 0);
  endtask

  // Monitor: every accepted byte and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (byte_valid[d] && byte_ready) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d.extra_byte actual=%0h required=none", d, byte_out[d]);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            checkOutput($sformatf("dut%0d.kind", d), 0, e.is_done);
            checkOutput($sformatf("dut%0d.byte", d), byte_out[d], e.data);
            checkOutput($sformatf("dut%0d.last", d), last[d], e.last);
          end
        end
        if (done[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d.extra_done actual=1 required=0", d);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            checkOutput($sformatf("dut%0d.done_kind", d), 1, e.is_done);
          end
          checkOutput($sformatf("dut%0d.done_valid", d), byte_valid[d], 0);
        end
        if (!byte_valid[d])
          checkOutput($sformatf("dut%0d.byte_idle", d), byte_out[d], 0);
      end
    end
  end

  initial begin
    int cycles;
    reset      = 1'b1;
    reg_data   = 32'h0;
    read_req   = 1'b0;
    byte_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 checkIdle("reset");
    reset = 1'b0;

    // Basic word, ready held high: four bytes, done, idle.
    $display("[TB] word DEADBEEF");
    pushWord(32'hDEADBEEF, 4, 1'b1);
    applyStimulus(32'hDEADBEEF);
    checkOutput("latency.valid0", byte_valid[0], 1);
    checkOutput("latency.busy0", busy[0], 1);
    waitDrain("deadbeef", 20, cycles);
    checkOutput("deadbeef.cycles", cycles, 6);

    // Stall on byte index 2 for three cycles.
    $display("[TB] word 12345678 with stall");
    pushWord(32'h12345678, 4, 1'b1);
    applyStimulus(32'h12345678);
    repeat (2) @(posedge clk);
    #1 byte_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall.byte0", byte_out[0], 8'h56);
      checkOutput("stall.byte1", byte_out[1], 8'h34);
      checkOutput("stall.valid0", byte_valid[0], 1);
      checkOutput("stall.valid1", byte_valid[1], 1);
    end
    @(posedge clk);
    #1 byte_ready = 1'b1;
    waitDrain("stall", 20, cycles);

    // Snapshot frozen, re-request ignored through SEND and DONE.
    $display("[TB] word CAFEF00D with re-request");
    pushWord(32'hCAFEF00D, 4, 1'b1);
    applyStimulus(32'hCAFEF00D);
    @(posedge clk);
    #1 reg_data = 32'h0;
    read_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 read_req = 1'b0;
    waitDrain("cafe", 20, cycles);
    repeat (3) begin
      @(negedge clk);
      checkOutput("cafe.no_second", busy[0] | busy[1], 0);
    end

    // Asynchronous reset after two bytes accepted discards the word.
    $display("[TB] reset mid-word");
    @(posedge clk);
    #1 pushWord(32'h89ABCDEF, 2, 1'b0);
    applyStimulus(32'h89ABCDEF);
    repeat (2) @(posedge clk);
    #1 byte_ready = 1'b0;
    #2 reset = 1'b1;
    #1 checkIdle("async_reset");
    checkOutput("async_reset.pending", exp_q[0].size() + exp_q[1].size(), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    byte_ready = 1'b1;
    checkIdle("after_reset");
    pushWord(32'h00000001, 4, 1'b1);
    applyStimulus(32'h00000001);
    waitDrain("one", 20, cycles);
    checkOutput("one.cycles", cycles, 6);

    // read_req held high: back-to-back words with one DONE and one IDLE cycle.
    $display("[TB] back-to-back words");
    @(posedge clk);
    #1 pushWord(32'h11223344, 4, 1'b1);
    pushWord(32'h55667788, 4, 1'b1);
    reg_data = 32'h11223344;
    read_req = 1'b1;
    @(posedge clk);
    #1 reg_data = 32'h55667788;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("b2b.idle_gap", busy[0] | busy[1], 0);
    @(posedge clk);
    #1 read_req = 1'b0;
    reg_data = 32'hFFFFFFFF;
    checkOutput("b2b.second_start", byte_valid[0] & byte_valid[1], 1);
    waitDrain("b2b", 20, cycles);
    checkOutput("b2b.cycles", cycles, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reg_reader.md
# reg_reader

Read-side companion to the 32-bit enable register: on request it snapshots a register's output word and streams it out one byte at a time over a valid/ready byte interface. The byte stream feeds the display/debug path (7-segment driver, UART transmitter) so a register value can be observed without stalling the datapath that owns the register. One request produces exactly WIDTH/8 byte transfers followed by a one-cycle completion pulse.

## Interface
Parameters:
- WIDTH, 32, width of the observed register; must be a multiple of 8
- MSB_FIRST, 1, 1 = most significant byte sent first; 0 = least significant byte first

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- reg_data  in  WIDTH  current output of the observed register
- read_req  in  1  start request, sampled only in IDLE
- busy  out  1  high in SEND and DONE
- byte_out  out  8  current byte; 0 when byte_valid is low
- byte_valid  out  1  byte_out holds a valid byte
- byte_ready  in  1  downstream accepts byte_out this cycle
- last  out  1  high with byte_valid on the final byte of the word
- done  out  1  one-cycle pulse after final byte accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: busy=0, byte_valid=0, done=0. If read_req=1 at a rising edge: reg_data captured into snapshot, byte index cleared to 0, go to SEND.
- SEND: byte_valid=1, busy=1; byte_out = snapshot byte selected by index (index 0 = bits [WIDTH-1:WIDTH-8] when MSB_FIRST=1, bits [7:0] when MSB_FIRST=0). last=1 when index = WIDTH/8-1.
- Transfer occurs on a rising edge with byte_valid=1 and byte_ready=1. On transfer: index increments; if last was set, go to DONE.
- Without transfer (byte_ready=0): byte_out, last, index hold unchanged; valid never drops mid-word.
- DONE: done=1, busy=1, byte_valid=0 for exactly one cycle; then IDLE unconditionally.
- read_req in SEND or DONE is ignored (not queued); requester must re-assert in IDLE.
- Snapshot is frozen from capture until next capture; reg_data changes during SEND do not affect output bytes.
- Index width: clog2(WIDTH/8), minimum 1 bit; never wraps because transfer on last leaves SEND.

## Timing
- Reset (asserted any time, including mid-word): state=IDLE, index=0, snapshot=0, busy=0, byte_valid=0, last=0, done=0, byte_out=0; partially sent word is discarded, no done pulse.
- Latency: read_req sampled at edge N -> byte_valid=1 in cycle following edge N.
- With byte_ready held high: transfers at edges N+1..N+WIDTH/8; done high in cycle after edge N+WIDTH/8; IDLE after next edge. Earliest next capture at edge N+WIDTH/8+2.
- All outputs registered or decoded from state/index/snapshot only; no combinational path from byte_ready or read_req to any output.
- byte_ready sampled only in SEND.

## Structure
- Shared package reg_reader_pkg: state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2), BYTES_PER_WORD = WIDTH/8, index width constant.
- Snapshot storage: one instance of the team's 32-bit `register` block (write_enable = capture condition, reset tied to reset); byte mux and FSM in reg_reader itself.

## Test plan
- Reset then read_req pulse with reg_data=32'hDEADBEEF, byte_ready=1, MSB_FIRST=1 -> bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF on consecutive cycles, last only on 8'hEF, done one cycle later, busy low after.
- Same word, MSB_FIRST=0 -> bytes 8'hEF, 8'hBE, 8'hAD, 8'hDE.
- reg_data=32'h12345678, byte_ready low for 3 cycles at byte 2 -> byte_out holds 8'h56 with valid high throughout stall, sequence completes unchanged.
- Capture 32'hCAFEF00D, change reg_data to 32'h0 during SEND, re-pulse read_req mid-word -> output still CA FE F0 0D, exactly one done pulse, no second word.
- Assert reset after second byte accepted -> all outputs 0 asynchronously, no done; next request with 32'h00000001 sends 00 00 00 01 correctly.
- read_req held high continuously, byte_ready=1 -> back-to-back words separated by one DONE cycle and one IDLE cycle, each word reflects reg_data at its own capture edge.
